mult4_rr_scheduler: RTL



---
 rtl/mult4_rr_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult4_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 unsigned array multiplier between NREQ requesters.
// Optional macro MULT4_OVERLAP_EN: arbitrate during the result handshake cycle for back-to-back issue.

module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);
  logic [3:0][7:0] pp;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = y[i] ? ({4'b0, x} << i) : 8'h00;
  end

  assign o = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module mult4_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [7:0]        res_prod,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  last, op_id, grant_id;
  logic [3:0]      op_x, op_y, sel_x, sel_y;
  logic [NREQ-1:0] grant_oh;
  logic            grant_any, arb_en;
  logic [7:0]      prod;
  int              idx;

  // First valid requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_id      = IDW'(idx);
        grant_oh[idx] = 1'b1;
        sel_x         = req_x[idx*4 +: 4];
        sel_y         = req_y[idx*4 +: 4];
      end
    end
  end

`ifdef MULT4_OVERLAP_EN
  assign arb_en = rst_n && ((state == IDLE) || ((state == DONE) && res_ready));
`else
  assign arb_en = rst_n && (state == IDLE);
`endif

  assign req_ready = arb_en ? grant_oh : '0;
  assign busy      = (state != IDLE);

  main u_mult (
    .x(op_x),
    .y(op_y),
    .o(prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ-1);
      op_x      <= '0;
      op_y      <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_prod  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_x  <= sel_x;
            op_y  <= sel_y;
            op_id <= grant_id;
            last  <= grant_id;
            state <= CALC;
          end
        end
        CALC: begin
          res_prod  <= prod;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef MULT4_OVERLAP_EN
            if (grant_any) begin
              op_x  <= sel_x;
              op_y  <= sel_y;
              op_id <= grant_id;
              last  <= grant_id;
              state <= CALC;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
